// File: rtl/stat_counter_types.sv
// Shared defaults for the statistics counter bank and its per-event counters.
package stat_counter_types;

  localparam int STAT_COUNTER_DEFAULT_W = 32;
  localparam int STAT_INC_DEFAULT_W     = 2;

endpackage

// File: rtl/stat_counter_bank_counter.sv
// Single event counter: multi-count increment, enable, synchronous clear,
// wrap or saturate on overflow, and a sticky overflow flag.
module stat_counter
  import stat_counter_types::*;
#(
  parameter int COUNTER_W = STAT_COUNTER_DEFAULT_W,
  parameter int INC_W     = STAT_INC_DEFAULT_W,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INC_W-1:0]     inc,
  input  logic                 en,
  input  logic                 clear,
  output logic [COUNTER_W-1:0] count,
  output logic                 overflow
);

  localparam int SUM_W = COUNTER_W + 1;

  logic [SUM_W-1:0]     sum;
  logic [COUNTER_W-1:0] count_next;
  logic                 overflow_next;

  // Next value: clear wins, otherwise add with a carry bit that signals overflow.
  always_comb begin
    sum           = {1'b0, count} + SUM_W'(inc);
    count_next    = count;
    overflow_next = overflow;
    if (clear) begin
      count_next    = '0;
      overflow_next = 1'b0;
    end else if (en) begin
      if (sum[COUNTER_W]) begin
        overflow_next = 1'b1;
        count_next    = SATURATE ? {COUNTER_W{1'b1}} : sum[COUNTER_W-1:0];
      end else begin
        count_next = sum[COUNTER_W-1:0];
      end
    end
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      count    <= count_next;
      overflow <= overflow_next;
    end
  end

endmodule

// File: rtl/stat_counter_bank.sv
// Bank of performance-event counters with an atomic snapshot copy and a
// one-cycle-latency read port into that snapshot.
module stat_counter_bank
  import stat_counter_types::*;
#(
  parameter int NUM_STATS = 28,
  parameter int COUNTER_W = STAT_COUNTER_DEFAULT_W,
  parameter int INC_W     = STAT_INC_DEFAULT_W,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_STATS*INC_W-1:0]   inc_amount,
  input  logic [NUM_STATS-1:0]         enable_mask,
  input  logic                         freeze,
  input  logic                         clear,
  input  logic                         snapshot_req,
  output logic                         snapshot_valid,
  input  logic                         rd_req,
  input  logic [$clog2(NUM_STATS)-1:0] rd_idx,
  output logic                         rd_valid,
  output logic [COUNTER_W-1:0]         rd_data,
  output logic                         rd_overflow,
  output logic                         rd_err
);

  localparam int IDX_W = $clog2(NUM_STATS);

  typedef struct packed {
    logic                 overflow;
    logic [COUNTER_W-1:0] value;
  } snap_entry_t;

  logic [COUNTER_W-1:0] live_count [NUM_STATS];
  logic [NUM_STATS-1:0] live_overflow;
  snap_entry_t          snap_q [NUM_STATS];

  logic                 rd_bad_idx;
  logic [IDX_W-1:0]     rd_sel;

  for (genvar i = 0; i < NUM_STATS; i++) begin : g_counter
    stat_counter #(
      .COUNTER_W (COUNTER_W),
      .INC_W     (INC_W),
      .SATURATE  (SATURATE)
    ) u_counter (
      .clk      (clk),
      .rst      (rst),
      .inc      (inc_amount[i*INC_W +: INC_W]),
      .en       (!freeze && enable_mask[i]),
      .clear    (clear),
      .count    (live_count[i]),
      .overflow (live_overflow[i])
    );
  end

  // Snapshot copies the registered live values, so it sees them before this
  // edge's increment or clear takes effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STATS; i++) begin
        snap_q[i] <= '0;
      end
      snapshot_valid <= 1'b0;
    end else if (snapshot_req) begin
      for (int i = 0; i < NUM_STATS; i++) begin
        snap_q[i] <= '{overflow: live_overflow[i], value: live_count[i]};
      end
      snapshot_valid <= 1'b1;
    end
  end

  // Out-of-range indices are steered to entry 0 so the array is never
  // indexed past its end; the response is zeroed anyway.
  always_comb begin
    rd_bad_idx = (32'(rd_idx) >= 32'(NUM_STATS));
    rd_sel     = rd_bad_idx ? '0 : rd_idx;
  end

  // Read response reads the snapshot as it stood before this edge, so a
  // simultaneous snapshot request does not affect the returned data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      rd_overflow <= 1'b0;
      rd_err      <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_err      <= rd_bad_idx;
        rd_data     <= rd_bad_idx ? '0   : snap_q[rd_sel].value;
        rd_overflow <= rd_bad_idx ? 1'b0 : snap_q[rd_sel].overflow;
      end
    end
  end

endmodule

// File: tb/tb_stat_counter_bank.sv
// Directed bench: one wrapping and one saturating 8-bit bank driven in parallel.
module tb_stat_counter_bank;

  localparam int NS  = 28;
  localparam int CW  = 8;
  localparam int IW  = 2;
  localparam int XW  = $clog2(NS);

  logic              clk = 1'b0;
  logic              rst;
  logic [NS*IW-1:0]  inc_amount;
  logic [NS-1:0]     enable_mask;
  logic              freeze;
  logic              clear;
  logic              snapshot_req;
  logic              rd_req;
  logic [XW-1:0]     rd_idx;

  logic              w_snapshot_valid, s_snapshot_valid;
  logic              w_rd_valid, s_rd_valid;
  logic [CW-1:0]     w_rd_data, s_rd_data;
  logic              w_rd_overflow, s_rd_overflow;
  logic              w_rd_err, s_rd_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stat_counter_bank #(.NUM_STATS(NS), .COUNTER_W(CW), .INC_W(IW), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .inc_amount(inc_amount), .enable_mask(enable_mask),
    .freeze(freeze), .clear(clear), .snapshot_req(snapshot_req),
    .snapshot_valid(w_snapshot_valid), .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_valid(w_rd_valid), .rd_data(w_rd_data), .rd_overflow(w_rd_overflow),
    .rd_err(w_rd_err)
  );

  stat_counter_bank #(.NUM_STATS(NS), .COUNTER_W(CW), .INC_W(IW), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .inc_amount(inc_amount), .enable_mask(enable_mask),
    .freeze(freeze), .clear(clear), .snapshot_req(snapshot_req),
    .snapshot_valid(s_snapshot_valid), .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_valid(s_rd_valid), .rd_data(s_rd_data), .rd_overflow(s_rd_overflow),
    .rd_err(s_rd_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inc(input int idx, input int val);
    inc_amount = '0;
    inc_amount[idx*IW +: IW] = IW'(val);
  endtask

  task automatic take_snapshot();
    snapshot_req = 1'b1;
    step();
    snapshot_req = 1'b0;
  endtask

  // Issue a single read; response is observable after one edge.
  task automatic do_read(input int idx);
    rd_req = 1'b1;
    rd_idx = XW'(idx);
    step();
    rd_req = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    inc_amount   = '0;
    enable_mask  = '1;
    freeze       = 1'b0;
    clear        = 1'b0;
    snapshot_req = 1'b0;
    rd_req       = 1'b0;
    rd_idx       = '0;

    #12;
    check("rst_snapshot_valid", 64'(w_snapshot_valid), 0);
    check("rst_rd_valid",       64'(w_rd_valid), 0);
    check("rst_rd_data",        64'(w_rd_data), 0);
    check("rst_rd_overflow",    64'(w_rd_overflow), 0);
    check("rst_rd_err",         64'(s_rd_err), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // 100 cycles of +3 on counter 0: 300 mod 256 = 44 when wrapping, 255 when saturating.
    set_inc(0, 3);
    repeat (100) step();
    inc_amount = '0;
    take_snapshot();
    check("snapshot_valid_set", 64'(w_snapshot_valid), 1);
    do_read(0);
    check("wrap_rd_valid",    64'(w_rd_valid), 1);
    check("wrap_rd_data",     64'(w_rd_data), 44);
    check("wrap_rd_overflow", 64'(w_rd_overflow), 1);
    check("sat_rd_data",      64'(s_rd_data), 255);
    check("sat_rd_overflow",  64'(s_rd_overflow), 1);

    // 10 more cycles: wrap moves to 74, saturate stays pinned.
    set_inc(0, 3);
    repeat (10) step();
    inc_amount = '0;
    take_snapshot();
    do_read(0);
    check("sat_hold_rd_data",    64'(s_rd_data), 255);
    check("sat_hold_overflow",   64'(s_rd_overflow), 1);
    check("wrap_again_rd_data",  64'(w_rd_data), 74);

    // Counter 5 to 20, then clear + increment + snapshot together.
    clear = 1'b1;
    step();
    clear = 1'b0;
    set_inc(5, 2);
    repeat (10) step();
    clear        = 1'b1;
    snapshot_req = 1'b1;
    step();
    clear      = 1'b0;
    inc_amount = '0;
    // Re-snapshot while reading: read returns the older snapshot (20).
    rd_req = 1'b1;
    rd_idx = XW'(5);
    step();
    snapshot_req = 1'b0;
    rd_req       = 1'b0;
    check("clr_snap_pre_value", 64'(w_rd_data), 20);
    check("clr_snap_pre_sat",   64'(s_rd_data), 20);
    do_read(5);
    check("clr_live_zero",      64'(w_rd_data), 0);
    check("clr_live_overflow",  64'(w_rd_overflow), 0);
    do_read(0);
    check("clr_ovf0_cleared",   64'(w_rd_overflow), 0);
    check("clr_cnt0_cleared",   64'(s_rd_data), 0);

    // Counter 3 to 4, then freeze 5 cycles and mask off 5 cycles.
    set_inc(3, 1);
    repeat (4) step();
    freeze = 1'b1;
    repeat (5) step();
    freeze         = 1'b0;
    enable_mask[3] = 1'b0;
    repeat (5) step();
    enable_mask[3] = 1'b1;
    inc_amount     = '0;
    take_snapshot();
    do_read(3);
    check("frz_mask_hold", 64'(w_rd_data), 4);
    set_inc(3, 1);
    step();
    inc_amount = '0;
    take_snapshot();
    do_read(3);
    check("mask_resume", 64'(w_rd_data), 5);
    do_read(4);
    check("mask_other_untouched", 64'(w_rd_data), 0);

    // Out-of-range index, last legal index, back-to-back reads.
    do_read(NS);
    check("err_rd_valid", 64'(w_rd_valid), 1);
    check("err_rd_err",   64'(w_rd_err), 1);
    check("err_rd_data",  64'(w_rd_data), 0);
    check("err_rd_ovf",   64'(w_rd_overflow), 0);
    do_read(NS - 1);
    check("last_idx_err",  64'(w_rd_err), 0);
    check("last_idx_data", 64'(w_rd_data), 0);
    rd_req = 1'b1;
    rd_idx = XW'(2);
    step();
    check("b2b_first_valid", 64'(w_rd_valid), 1);
    check("b2b_first_err",   64'(w_rd_err), 0);
    step();
    rd_req = 1'b0;
    check("b2b_second_valid", 64'(w_rd_valid), 1);
    step();
    check("rd_valid_pulse_end", 64'(w_rd_valid), 0);

    // Reset mid-count with a read in flight.
    set_inc(1, 3);
    repeat (4) step();
    take_snapshot();
    do_read(1);
    check("pre_rst_value", 64'(w_rd_data), 12);
    rd_req = 1'b1;
    rd_idx = XW'(1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_rd_valid",       64'(w_rd_valid), 0);
    check("rst_mid_snapshot_valid", 64'(w_snapshot_valid), 0);
    check("rst_mid_rd_data",        64'(w_rd_data), 0);
    step();
    check("rst_dropped_response", 64'(w_rd_valid), 0);
    rst        = 1'b0;
    rd_req     = 1'b0;
    inc_amount = '0;
    step();
    take_snapshot();
    check("post_rst_snapshot_valid", 64'(w_snapshot_valid), 1);
    do_read(1);
    check("post_rst_cnt1", 64'(w_rd_data), 0);
    do_read(0);
    check("post_rst_cnt0",     64'(s_rd_data), 0);
    check("post_rst_ovf0",     64'(w_rd_overflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stat_counter_bank.md
Name: stat_counter_bank

Overview:
Parametrised bank of performance-event counters indexed by the stats_t enumeration in cva5_types. Supports multi-count increments per cycle, per-counter enable mask, freeze, synchronous clear, wrap or saturate mode, sticky overflow flags, and an atomic snapshot bank with a one-cycle-latency read port. It sits beside the fetch, issue and load-store units, collects their stall/hit/miss pulses, and is read by CSR or debug logic.

Parameters:
NUM_STATS, 28, number of counters; default equals entry count of stats_t
COUNTER_W, 32, counter width in bits (legal range 4..64)
INC_W, 2, width of per-counter increment amount (max increment 2^INC_W-1 per cycle)
SATURATE, 0, 0 = wrap modulo 2^COUNTER_W; 1 = clamp at all-ones

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
inc_amount  in  NUM_STATS*INC_W  per-counter increment this cycle; counter i uses bits [i*INC_W +: INC_W]
enable_mask  in  NUM_STATS  counter i accumulates only when bit i is 1
freeze  in  1  when 1, no counter accumulates
clear  in  1  synchronous clear of all live counters and overflow flags
snapshot_req  in  1  copy all live counters and overflow flags into the snapshot bank
snapshot_valid  out  1  snapshot bank holds a capture since reset
rd_req  in  1  read request from snapshot bank
rd_idx  in  $clog2(NUM_STATS)  counter index to read
rd_valid  out  1  read response valid
rd_data  out  COUNTER_W  snapshot counter value
rd_overflow  out  1  snapshot sticky overflow flag
rd_err  out  1  rd_idx >= NUM_STATS

Behaviour:
- Reset (async): all live counters, overflow flags, snapshot values and snapshot overflow flags = 0; snapshot_valid=0, rd_valid=0, rd_data=0, rd_overflow=0, rd_err=0.
- Accumulate per cycle, counter i: if !freeze && enable_mask[i] && !clear, next = count + inc_amount[i].
- Width: sum computed at COUNTER_W+1 bits; carry-out means overflow.
- Wrap mode: next = sum[COUNTER_W-1:0]; overflow flag set on carry-out.
- Saturate mode: on carry-out, next = all-ones, overflow set; at all-ones with nonzero increment, count stays, overflow set.
- Overflow flags are sticky; cleared only by clear or rst.
- clear has priority over accumulate in the same cycle: next count = 0, overflow = 0, regardless of inc_amount.
- snapshot_req: snapshot bank captures live register values as they are at this clock edge, i.e. before this cycle's increment or clear. snapshot_valid goes to 1 on the following cycle and stays 1.
- snapshot_req and clear in the same cycle: the snapshot holds the pre-clear values, and the live counters become 0.
- Read port: no backpressure. rd_req in cycle N gives rd_valid=1 in cycle N+1, with rd_data and rd_overflow from the snapshot bank as it stood at the end of cycle N.
- Read and snapshot in the same cycle: the read returns the old snapshot contents.
- rd_idx >= NUM_STATS: rd_valid=1, rd_err=1, rd_data=0, rd_overflow=0.
- rd_valid is a single-cycle pulse per request. Back-to-back requests give back-to-back responses.
- Reset asserted mid-operation: all state is zeroed immediately, and any pending read response is dropped.

Decomposition:
- Package stat_counter_types holds the snapshot entry struct {logic overflow; logic[COUNTER_W-1:0] value;}.
  - As a packed struct with a parameterised width, it lives as a localparam-based typedef inside the module.
  - The package carries STAT_COUNTER_DEFAULT_W=32 and STAT_INC_DEFAULT_W=2.
- stats_t and instruction_mix_stats_t stay in cva5_types. NUM_STATS at instantiation is derived from stats_t.num().
- One sub-module, stat_counter: a single counter with increment, clear, enable, wrap/saturate mode and a sticky overflow flag. It is instantiated NUM_STATS times in a generate loop. The bank adds the snapshot storage and the read port.

Test Plan:
- COUNTER_W=8, SATURATE=0, inc_amount[0]=3 for 100 cycles, mask all-ones → counter0 = 300 mod 256 = 44, overflow0 = 1. Check via snapshot_req then rd_req idx 0: rd_data=44, rd_overflow=1.
- COUNTER_W=8, SATURATE=1, same stimulus → rd_data=255, rd_overflow=1. Then a further 10 cycles of increment and a re-snapshot → still 255.
- Counter 5 at value 20, assert clear together with inc_amount[5]=2 and snapshot_req in the same cycle → snapshot reads 20. Live counter = 0; a re-snapshot one cycle later reads 0, overflow 0.
- Freeze held 5 cycles, then enable_mask[3]=0 with inc_amount[3]=1 for 5 cycles → counter 3 unchanged. Increment resumes the cycle after mask bit 3 returns to 1.
- rd_req with rd_idx=NUM_STATS (28) → next cycle rd_valid=1, rd_err=1, rd_data=0. rd_req idx 2 on consecutive cycles → two consecutive rd_valid pulses.
- Async rst asserted mid-count with a pending read (rd_req in the preceding cycle) → rd_valid=0, snapshot_valid=0, and all reads after reset + snapshot return 0.
